// File: rtl/pc_if_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, word geometry
// and the next-PC select encoding used by the fetch stage and the hazard unit.
package pc_if_pkg;

   localparam int XLEN       = 32;
   localparam int INST_BYTES = 4;
   localparam int ADDR_W     = XLEN - 2;
   localparam int CNT_W      = 16;

   localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0]  PC_STEP          = XLEN'(INST_BYTES);
   localparam logic [CNT_W-1:0] CNT_MAX          = '1;

   typedef enum logic [1:0] {
      PCSEL_EX   = 2'd0,
      PCSEL_ID   = 2'd1,
      PCSEL_HOLD = 2'd2,
      PCSEL_SEQ  = 2'd3
   } pc_sel_e;

   function automatic logic isRedirect(input pc_sel_e sel);
      return (sel == PCSEL_EX) || (sel == PCSEL_ID);
   endfunction

endpackage

// File: rtl/pc_if_next_sel.sv
// Combinational next-PC priority mux: EX redirect, ID redirect, stall, sequential.
module pc_next_sel
   import pc_if_pkg::*;
(
   input  logic [XLEN-1:0] i_pcIF,
   input  logic            i_bubbleF,
   input  logic            i_jalID,
   input  logic [XLEN-1:0] i_jalTargetID,
   input  logic            i_brJalrEX,
   input  logic [XLEN-1:0] i_brTargetEX,
   output logic [XLEN-1:0] o_pcNext,
   output pc_sel_e         o_sel
);

   // EX wins over a stalled or active JAL because its instruction is older.
   always_comb begin
      o_sel    = PCSEL_SEQ;
      o_pcNext = i_pcIF + PC_STEP;
      if (i_brJalrEX) begin
         o_sel    = PCSEL_EX;
         o_pcNext = i_brTargetEX;
      end else if (i_jalID && !i_bubbleF) begin
         o_sel    = PCSEL_ID;
         o_pcNext = i_jalTargetID;
      end else if (i_bubbleF) begin
         o_sel    = PCSEL_HOLD;
         o_pcNext = i_pcIF;
      end
   end

endmodule

// File: rtl/pc_if.sv
// Instruction-fetch stage: program counter, cache address, ID-aligned PC copy.
// Optional macro PC_IF_MISALIGN_TRAP_EN adds misalign_ID for unaligned redirects.
module pc_if
   import pc_if_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bubbleF,
   input  logic              flushF,
   input  logic              bubbleD,
   input  logic              flushD,
   input  logic              jal_ID,
   input  logic [XLEN-1:0]   jal_target_ID,
   input  logic              br_jalr_EX,
   input  logic [XLEN-1:0]   br_target_EX,
   output logic [ADDR_W-1:0] addr_IF,
   output logic [XLEN-1:0]   pc_IF,
   output logic [XLEN-1:0]   pc_ID,
   output logic [XLEN-1:0]   pc4_ID,
   output logic              valid_ID,
`ifdef PC_IF_MISALIGN_TRAP_EN
   output logic              misalign_ID,
`endif
   output logic [CNT_W-1:0]  redirect_cnt
);

   logic [XLEN-1:0]  r_pcIF;
   logic [XLEN-1:0]  r_pcID;
   logic             r_validID;
   logic [CNT_W-1:0] r_redirectCnt;
   logic [XLEN-1:0]  w_pcNext;
   pc_sel_e          w_sel;
   logic             w_redirect;
   logic             w_unusedFlushF;

   // Redirects already supersede an IF flush, so flushF has nothing to do here.
   assign w_unusedFlushF = flushF;

   pc_next_sel u_nextSel (
      .i_pcIF        (r_pcIF),
      .i_bubbleF     (bubbleF),
      .i_jalID       (jal_ID),
      .i_jalTargetID (jal_target_ID),
      .i_brJalrEX    (br_jalr_EX),
      .i_brTargetEX  (br_target_EX),
      .o_pcNext      (w_pcNext),
      .o_sel         (w_sel)
   );

   assign w_redirect = isRedirect(w_sel);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pcIF        <= RESET_PC;
         r_redirectCnt <= '0;
      end else begin
         r_pcIF <= w_pcNext;
         if (w_redirect && (r_redirectCnt != CNT_MAX))
            r_redirectCnt <= r_redirectCnt + 1'b1;
      end
   end

   // Bubble beats flush so this register stays in lockstep with IR_ID.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pcID    <= '0;
         r_validID <= 1'b0;
      end else if (!bubbleD) begin
         if (flushD) begin
            r_pcID    <= '0;
            r_validID <= 1'b0;
         end else begin
            r_pcID    <= r_pcIF;
            r_validID <= 1'b1;
         end
      end
   end

`ifdef PC_IF_MISALIGN_TRAP_EN
   logic r_misalignIF;
   logic r_misalignID;

   // The flag rides with the PC it describes: set at IF on an unaligned
   // redirect, cleared when IF moves on, then follows that PC into ID.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_misalignIF <= 1'b0;
         r_misalignID <= 1'b0;
      end else begin
         if (w_sel != PCSEL_HOLD)
            r_misalignIF <= w_redirect && (w_pcNext[1:0] != 2'b00);
         if (!bubbleD)
            r_misalignID <= flushD ? 1'b0 : r_misalignIF;
      end
   end

   assign misalign_ID = r_misalignID;
`endif

   assign pc_IF        = r_pcIF;
   assign addr_IF      = r_pcIF[XLEN-1:2];
   assign pc_ID        = r_pcID;
   assign pc4_ID       = r_pcID + PC_STEP;
   assign valid_ID     = r_validID;
   assign redirect_cnt = r_redirectCnt;

endmodule
